alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: width, 9, operand/result bit width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports per requester i in {0,1}: req<i>_valid input 1; req<i>_ready output 1; req<i>_a input width; req<i>_b input width; req<i>_op input 1 (0 add, 1 sub).
REQ-005 SHALL have ports per requester i: rsp<i>_valid output 1; rsp<i>_ready input 1; rsp<i>_c output width; rsp<i>_flags output 3, packed {OF,SF,ZF}.
REQ-006 SHALL have ports to shared ALU: alu_a output width; alu_b output width; alu_op output 1; alu_c input width, combinational result of current alu_a/alu_b/alu_op; alu_zf, alu_sf, alu_of inputs 1, registered by ALU one clk after the operands.
REQ-007 SHALL have port: busy output 1, high whenever state is not IDLE.

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> FLAGS -> RESP -> IDLE, one state per cycle except RESP.
REQ-009 IDLE: req<i>_ready SHALL be high only for the granted requester, combinationally, while state is IDLE and rst is low; all other ready outputs low.
REQ-010 Grant SHALL be round-robin: only one valid -> that one; both valid -> the one not equal to last_grant; last_grant updates on accept.
REQ-011 On accept (valid & ready), operands, op and requester id SHALL be latched; next state ISSUE.
REQ-012 alu_a/alu_b/alu_op SHALL be driven from the latched registers in all states, holding values between operations.
REQ-013 ISSUE: alu_c SHALL be captured into the result register at the end of the cycle; next state FLAGS.
REQ-014 FLAGS: alu_of/alu_sf/alu_zf SHALL be captured into the flag register at the end of the cycle; next state RESP.
REQ-015 RESP: rsp<id>_valid SHALL be high with rsp<id>_c/flags stable; other rsp_valid low; exit to IDLE when rsp<id>_ready is high.
REQ-016 Latency: accept at edge T -> rsp_valid first high in the cycle following edge T+2 (3 cycles); throughput max one operation per 4 cycles.
REQ-017 No new request SHALL be accepted while rsp_valid is held (back-pressure stalls arbiter).
REQ-018 Arithmetic SHALL be performed solely by the shared ALU; controller passes result and flags through unmodified (wrap-around at width bits).
REQ-019 A requester dropping valid before ready SHALL lose nothing; no state change.

Reset
REQ-020 While rst high: state IDLE, all req_ready and rsp_valid low, busy low, operand/result/flag registers 0, last_grant = 1 (req0 wins first tie).
REQ-021 rst in any state SHALL abort the operation in flight; no response is produced for it.

Structure
REQ-022 Shared package SHALL hold FSM state encoding (IDLE, ISSUE, FLAGS, RESP) and flag bit-index constants (ZF=0, SF=1, OF=2).
REQ-023 Round-robin selection SHALL be a sub-module rr_arb2 (inputs valid[1:0], last_grant; output grant, any).
REQ-024 The shared ALU SHALL be external; the bench connects a behavioural add/sub ALU with flags registered one cycle.

Verification
REQ-025 req0 a=5 b=3 op=0, rsp0_ready=1 -> rsp0_c=8, flags=000, rsp_valid 3 cycles after accept.
REQ-026 req1 a=3 b=5 op=1 -> rsp1_c=9'h1FE, flags SF=1, ZF=0; a=7 b=7 op=1 -> c=0, ZF=1.
REQ-027 req0 a=9'h0FF b=9'h0FF op=0 -> c=9'h1FE, OF=1, SF=1.
REQ-028 req0 and req1 valid together from reset, held -> req0 served, then req1, then req0; no starvation.
REQ-029 rsp0_ready low 5 cycles in RESP -> rsp0_valid and data stable, req1_ready stays low; completes on ready.
REQ-030 rst pulsed during FLAGS -> next cycle IDLE, no rsp_valid, busy low; subsequent request completes normally.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: controller states
// and the bit positions of the packed {OF,SF,ZF} flag word.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLAGS = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int ZF     = 0;
  localparam int SF     = 1;
  localparam int OF     = 2;
  localparam int NFLAGS = 3;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the one
// that did not win last time gets the grant.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  assign any   = |valid;
  assign grant = (&valid) ? ~last_grant : valid[1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external add/sub ALU between two requesters. One operation is
// in flight at a time: latch operands, capture result, capture flags, respond.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int width = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [width-1:0]  req0_a,
  input  logic [width-1:0]  req0_b,
  input  logic              req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [width-1:0]  req1_a,
  input  logic [width-1:0]  req1_b,
  input  logic              req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [width-1:0]  rsp0_c,
  output logic [NFLAGS-1:0] rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [width-1:0]  rsp1_c,
  output logic [NFLAGS-1:0] rsp1_flags,
  output logic [width-1:0]  alu_a,
  output logic [width-1:0]  alu_b,
  output logic              alu_op,
  input  logic [width-1:0]  alu_c,
  input  logic              alu_zf,
  input  logic              alu_sf,
  input  logic              alu_of,
  output logic              busy
);

  state_t              r_state, w_next;
  logic                r_last_grant, r_id, r_op;
  logic [width-1:0]    r_a, r_b, r_c;
  logic [NFLAGS-1:0]   r_flags;
  logic                w_grant, w_any, w_idle, w_accept, w_rsp_ready;

  rr_arb2 u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .any        (w_any)
  );

  // Ready is gated by rst so nothing can be handshaken during reset.
  assign w_idle      = (r_state == IDLE) && !rst;
  assign req0_ready  = w_idle && w_any && !w_grant;
  assign req1_ready  = w_idle && w_any &&  w_grant;
  assign w_accept    = w_idle && w_any;
  assign w_rsp_ready = r_id ? rsp1_ready : rsp0_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ISSUE;
      ISSUE:   w_next = FLAGS;
      FLAGS:   w_next = RESP;
      RESP:    if (w_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // The ALU registers its flags one clock after the operands, so result and
  // flags are captured in consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 1'b0;
      r_c          <= '0;
      r_flags      <= '0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant;
        r_id         <= w_grant;
        r_a          <= w_grant ? req1_a  : req0_a;
        r_b          <= w_grant ? req1_b  : req0_b;
        r_op         <= w_grant ? req1_op : req0_op;
      end
      if (r_state == ISSUE) r_c <= alu_c;
      if (r_state == FLAGS) begin
        r_flags[OF] <= alu_of;
        r_flags[SF] <= alu_sf;
        r_flags[ZF] <= alu_zf;
      end
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign busy       = !rst && (r_state != IDLE);
  assign rsp0_valid = !rst && (r_state == RESP) && !r_id;
  assign rsp1_valid = !rst && (r_state == RESP) &&  r_id;
  assign rsp0_c     = r_c;
  assign rsp1_c     = r_c;
  assign rsp0_flags = r_flags;
  assign rsp1_flags = r_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, cycle-level reference model with a
// per-cycle compare process, directed cases with literal expectations, then random traffic.
module tb_alu_arbiter;

  logic       clk, rst;
  logic       req0_valid, req0_ready, req0_op, req1_valid, req1_ready, req1_op;
  logic [8:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [8:0] rsp0_c, rsp1_c;
  logic [2:0] rsp0_flags, rsp1_flags;
  logic [8:0] alu_a, alu_b, alu_c;
  logic       alu_op, alu_zf, alu_sf, alu_of, busy;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.width(9)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: combinational result, flags registered one clock later.
  assign alu_c = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_zf <= 1'b0; alu_sf <= 1'b0; alu_of <= 1'b0;
    end else begin
      alu_zf <= (alu_c == 9'd0);
      alu_sf <= alu_c[8];
      alu_of <= alu_op ? ((alu_a[8] != alu_b[8]) && (alu_c[8] != alu_a[8]))
                       : ((alu_a[8] == alu_b[8]) && (alu_c[8] != alu_a[8]));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from signed integer ranges: returns {OF,SF,ZF,c[8:0]}.
  function automatic logic [11:0] ref_alu(input int a, input int b, input int op);
    int sa, sb, full, c;
    logic of, sf, zf;
    sa   = (a >= 256) ? a - 512 : a;
    sb   = (b >= 256) ? b - 512 : b;
    full = op ? sa - sb : sa + sb;
    c    = (op ? a - b : a + b) & 511;
    of   = (full > 255) || (full < -256);
    sf   = (c >= 256);
    zf   = (c == 0);
    return {of, sf, zf, c[8:0]};
  endfunction

  // Model: one transaction record with an age counter since acceptance.
  logic       m_have = 1'b0, m_id = 1'b0, m_last = 1'b1, m_op = 1'b0;
  int         m_age = 0;
  logic [8:0] m_a = '0, m_b = '0, m_c = '0;
  logic [2:0] m_f = '0;

  always @(negedge clk) begin
    logic       g, e_r0, e_r1, e_v0, e_v1;
    logic [11:0] r;
    g = (req0_valid && req1_valid) ? !m_last : req1_valid;
    e_r0 = !rst && !m_have && req0_valid && !g;
    e_r1 = !rst && !m_have && req1_valid &&  g;
    e_v0 = !rst && m_have && (m_age >= 3) && !m_id;
    e_v1 = !rst && m_have && (m_age >= 3) &&  m_id;
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("busy", busy, !rst && m_have);
    chk("rsp0_valid", rsp0_valid, e_v0);
    chk("rsp1_valid", rsp1_valid, e_v1);
    chk("alu_operands", {alu_op, alu_a, alu_b}, {m_op, m_a, m_b});
    if (e_v0) chk("rsp0_data", {rsp0_flags, rsp0_c}, {m_f, m_c});
    if (e_v1) chk("rsp1_data", {rsp1_flags, rsp1_c}, {m_f, m_c});
    if (rst) begin
      m_have = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_op = 1'b0;
    end else if (m_have) begin
      if (m_age < 3) m_age++;
      else if (m_id ? rsp1_ready : rsp0_ready) m_have = 1'b0;
    end else if (req0_valid || req1_valid) begin
      m_have = 1'b1; m_age = 1; m_id = g; m_last = g;
      m_a  = g ? req1_a  : req0_a;
      m_b  = g ? req1_b  : req0_b;
      m_op = g ? req1_op : req0_op;
      r = ref_alu(int'(m_a), int'(m_b), int'(m_op));
      m_c = r[8:0];
      m_f = r[11:9];
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int id, input logic v, input int a, input int b, input int op);
    if (id == 0) begin req0_valid = v; req0_a = 9'(a); req0_b = 9'(b); req0_op = op[0]; end
    else         begin req1_valid = v; req1_a = 9'(a); req1_b = 9'(b); req1_op = op[0]; end
  endtask

  task automatic wait_ready(input int id, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (id == 0) ? req0_ready : req1_ready;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int id, output int k);
    logic seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      seen = (id == 0) ? rsp0_valid : rsp1_valid;
    end
    if (!seen) chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 30);
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  task automatic do_op(input int id, input int a, input int b, input int op,
                       input int exp_c, input int exp_f);
    logic ok;
    int   k;
    step();
    set_req(id, 1'b1, a, b, op);
    wait_ready(id, ok);
    step();
    set_req(id, 1'b0, a, b, op);
    if (!ok) return;
    wait_rsp(id, k);
    chk("latency", k, 3);
    if (id == 0) chk("c_flags0", {rsp0_flags, rsp0_c}, {exp_f[2:0], exp_c[8:0]});
    else         chk("c_flags1", {rsp1_flags, rsp1_c}, {exp_f[2:0], exp_c[8:0]});
    wait_idle();
  endtask

  initial begin
    int   ord[$];
    logic ok;
    int   k;
    rst = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);

    // Both requesters held valid from reset: req0, req1, req0.
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 1, 1, 0);
    set_req(1, 1'b1, 2, 2, 0);
    for (int i = 0; i < 60 && ord.size() < 3; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) ord.push_back(0);
      if (req1_valid && req1_ready) ord.push_back(1);
    end
    step();
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    chk("rr_count", ord.size(), 3);
    if (ord.size() == 3) begin
      chk("rr_first", ord[0], 0);
      chk("rr_second", ord[1], 1);
      chk("rr_third", ord[2], 0);
    end
    wait_idle();

    do_op(0, 5, 3, 0, 8, 3'b000);
    do_op(1, 3, 5, 1, 9'h1FE, 3'b010);
    do_op(1, 7, 7, 1, 0, 3'b001);
    do_op(0, 9'h0FF, 9'h0FF, 0, 9'h1FE, 3'b110);

    // Back-pressure in RESP: data held, other requester not accepted.
    step();
    rsp0_ready = 1'b0;
    set_req(0, 1'b1, 10, 4, 0);
    wait_ready(0, ok);
    step();
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b1, 1, 1, 0);
    wait_rsp(0, k);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp0_valid, 1);
      chk("bp_c", rsp0_c, 14);
      chk("bp_req1_ready", req1_ready, 0);
    end
    step();
    rsp0_ready = 1'b1;
    wait_ready(1, ok);
    step();
    set_req(1, 1'b0, 0, 0, 0);
    wait_rsp(1, k);
    chk("bp_next_c", rsp1_c, 2);
    wait_idle();

    // Reset during FLAGS aborts the operation.
    step();
    set_req(0, 1'b1, 20, 5, 1);
    wait_ready(0, ok);
    step();
    set_req(0, 1'b0, 0, 0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rsp", rsp0_valid, 0);
    do_op(0, 1, 2, 0, 3, 3'b000);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step();
      rst        = ($urandom_range(0, 63) == 0);
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      set_req(0, 1'($urandom_range(0, 1)), $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 1));
      set_req(1, 1'($urandom_range(0, 1)), $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 1));
    end
    step();
    rst = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    wait_idle();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
